// File: rtl/batch_lut_feeder_pkg.sv
// Shared definitions for the estimation-filter input stage.
//   rd_state_t   : reader FSM states
//   addr_width() : batch address width for a given DEPTH
//   float32_t / complex32_t : default float and complex types
package batch_p;

    typedef enum logic {IDLE, READ} rd_state_t;

    function automatic int unsigned addr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } float32_t;

    typedef struct packed {
        float32_t r;
        float32_t i;
    } complex32_t;

endpackage

// File: rtl/batch_lut_feeder_ram.sv
// Dual-bank simple dual-port RAM holding two batches of control vectors.
//   clk                          : clock
//   we, wr_bank, wr_addr, wr_data : write port
//   re, rd_bank, rd_addr         : read request
//   rd_data                      : registered read data, 1-cycle latency
// The contents are intentionally not reset.
module batch_ram
    import batch_p::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = addr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_data,
    input  logic          re,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [N-1:0]  rd_data
);

    logic [N-1:0] mem [2*DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
        if (re) begin
            rd_data <= mem[{rd_bank, rd_addr}];
        end
    end

endmodule

// File: rtl/batch_lut_feeder.sv
// Input stage of the floating-point estimation filter: captures control
// vectors into a ping-pong batch buffer, replays each completed batch
// newest-first, and maps every replayed vector through a writable
// coefficient LUT.
//   clk, rst                    : clock, synchronous active-high reset
//   in_ctrl, in_valid           : control vector stream (max 1/clock)
//   lut_we, lut_addr, lut_data  : LUT write port
//   out, out_valid              : LUT[ctrl] for the replayed sample
//   out_first / out_last        : newest / oldest sample of a batch
module batch_lut_feeder
    import batch_p::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned f_exp  = 8,
    parameter int unsigned f_mant = 23,
    parameter type float_t   = float32_t,
    parameter type complex_t = complex32_t
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_ctrl,
    input  logic         in_valid,
    input  logic         lut_we,
    input  logic [N-1:0] lut_addr,
    input  complex_t     lut_data,
    output complex_t     out,
    output logic         out_valid,
    output logic         out_first,
    output logic         out_last
);

    localparam int unsigned   AW   = addr_width(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    // The type parameters must agree with the float field widths.
    if ($bits(float_t) != 1 + f_exp + f_mant || $bits(complex_t) != 2 * $bits(float_t)) begin : g_bad_types
        $error("batch_lut_feeder: float_t/complex_t do not match f_exp/f_mant");
    end

    // ---------------- writer ----------------
    logic [AW-1:0] wr_ptr;
    logic          wr_bank;
    logic          batch_done;

    assign batch_done = in_valid && (wr_ptr == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            wr_bank <= 1'b0;
        end else if (in_valid) begin
            wr_ptr <= wr_ptr + 1'b1;   // DEPTH is a power of two: wraps to 0
            if (batch_done) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // ---------------- reader FSM ----------------
    // The read request (re, ra, ra_bank, tags) is registered, so the RAM
    // sees address DEPTH-1 one clock after the batch completes.
    rd_state_t     state;
    logic          rd_bank;
    logic [AW-1:0] rd_ptr;
    logic          re;
    logic          ra_bank;
    logic [AW-1:0] ra;
    logic          re_first;
    logic          re_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rd_bank  <= 1'b0;
            rd_ptr   <= '0;
            re       <= 1'b0;
            ra_bank  <= 1'b0;
            ra       <= '0;
            re_first <= 1'b0;
            re_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    re       <= 1'b0;
                    re_first <= 1'b0;
                    re_last  <= 1'b0;
                    if (batch_done) begin
                        rd_bank <= wr_bank;
                        rd_ptr  <= LAST;
                        state   <= READ;
                    end
                end
                READ: begin
                    re       <= 1'b1;
                    ra       <= rd_ptr;
                    ra_bank  <= rd_bank;
                    re_first <= (rd_ptr == LAST);
                    re_last  <= (rd_ptr == '0);
                    rd_ptr   <= rd_ptr - 1'b1;
                    if (rd_ptr == '0) begin
                        // Back-to-back batches: restart on the new bank with no bubble.
                        if (batch_done) begin
                            rd_bank <= wr_bank;
                            rd_ptr  <= LAST;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // ---------------- stage 1: RAM read ----------------
    logic [N-1:0] ctrl_q;
    logic         v1;
    logic         f1;
    logic         l1;

    batch_ram #(
        .N     (N),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we      (in_valid),
        .wr_bank (wr_bank),
        .wr_addr (wr_ptr),
        .wr_data (in_ctrl),
        .re      (re),
        .rd_bank (ra_bank),
        .rd_addr (ra),
        .rd_data (ctrl_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            f1 <= 1'b0;
            l1 <= 1'b0;
        end else begin
            v1 <= re;
            f1 <= re_first;
            l1 <= re_last;
        end
    end

    // ---------------- coefficient LUT ----------------
    complex_t lut [2**N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2**N; i++) begin
                lut[i] <= '0;
            end
        end else if (lut_we) begin
            lut[lut_addr] <= lut_data;
        end
    end

    // ---------------- stage 2: output register ----------------
    // A same-cycle LUT write is not yet visible here, so the old entry is used.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= v1;
            out_first <= f1;
            out_last  <= l1;
            if (v1) begin
                out <= lut[ctrl_q];
            end
        end
    end

endmodule

// File: tb/tb_batch_lut_feeder.sv
module tb_batch_lut_feeder;
    import batch_p::*;

    localparam int unsigned N     = 4;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT
    logic         rst;
    logic [N-1:0] in_ctrl;
    logic         in_valid;
    logic         lut_we;
    logic [N-1:0] lut_addr;
    complex32_t   lut_data;
    complex32_t   out;
    logic         out_valid, out_first, out_last;

    batch_lut_feeder #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_ctrl(in_ctrl), .in_valid(in_valid),
        .lut_we(lut_we), .lut_addr(lut_addr), .lut_data(lut_data),
        .out(out), .out_valid(out_valid), .out_first(out_first), .out_last(out_last)
    );

    // small corner DUT: DEPTH=4, N=1
    logic       s_rst;
    logic [0:0] s_ctrl;
    logic       s_valid;
    logic       s_lut_we;
    logic [0:0] s_lut_addr;
    complex32_t s_lut_data;
    complex32_t s_out;
    logic       s_out_valid, s_out_first, s_out_last;

    batch_lut_feeder #(.N(1), .DEPTH(4)) dut4 (
        .clk(clk), .rst(s_rst), .in_ctrl(s_ctrl), .in_valid(s_valid),
        .lut_we(s_lut_we), .lut_addr(s_lut_addr), .lut_data(s_lut_data),
        .out(s_out), .out_valid(s_out_valid), .out_first(s_out_first), .out_last(s_out_last)
    );

    int npass = 0;
    int ntot  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        ntot++;
        if (act === expv) npass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    endtask

    function automatic logic [31:0] mkf(input int v);
        int unsigned a;
        int          e;
        logic [31:0] r;
        if (v == 0) return 32'h0;
        a = (v < 0) ? -v : v;
        e = 0;
        for (int b = 0; b < 32; b++) if (a[b]) e = b;
        r[31]    = (v < 0);
        r[30:23] = 8'(127 + e);
        r[22:0]  = 23'(a << (23 - e));
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    // Each completed batch schedules its outputs, newest first, at the
    // cycles 3..DEPTH+2 after the last accept; the value is whatever the
    // LUT holds just before that output edge.
    typedef struct {
        logic [N-1:0] ctrl;
        bit           first;
        bit           last;
    } exp_t;

    exp_t         sched [int];
    logic [N-1:0] batch_q [$];
    complex32_t   lut_m [2**N];
    exp_t         ent;
    int           cyc = 0;
    bit           mon_on = 0;
    bit           post_rst = 0;
    bit           exp_valid = 0, exp_first = 0, exp_last = 0;
    complex32_t   exp_out = '0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            sched.delete();
            batch_q.delete();
            foreach (lut_m[i]) lut_m[i] = '0;
            exp_valid = 0; exp_first = 0; exp_last = 0; exp_out = '0;
            post_rst  = 1;
            mon_on    = 1;
        end else begin
            post_rst = 0;
            if (sched.exists(cyc)) begin
                ent       = sched[cyc];
                exp_valid = 1;
                exp_first = ent.first;
                exp_last  = ent.last;
                exp_out   = lut_m[ent.ctrl];
                sched.delete(cyc);
            end else begin
                exp_valid = 0; exp_first = 0; exp_last = 0;
            end
            if (lut_we) lut_m[lut_addr] = lut_data;
            if (in_valid) begin
                batch_q.push_back(in_ctrl);
                if (batch_q.size() == DEPTH) begin
                    for (int j = 0; j < DEPTH; j++)
                        sched[cyc + 3 + j] = '{ctrl: batch_q[DEPTH-1-j], first: (j == 0), last: (j == DEPTH-1)};
                    batch_q.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            chk("out_valid", 64'(out_valid), 64'(exp_valid));
            chk("out_first", 64'(out_first), 64'(exp_first));
            chk("out_last",  64'(out_last),  64'(exp_last));
            if (exp_valid)     chk("out", out, exp_out);
            else if (post_rst) chk("out_after_rst", out, 64'h0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load_lut();
        for (int i = 0; i < 2**N; i++) begin
            lut_we   = 1'b1;
            lut_addr = N'(i);
            lut_data = {mkf(i), mkf(-i)};
            @(negedge clk);
        end
        lut_we = 1'b0;
    endtask

    task automatic send(input logic [N-1:0] c);
        in_ctrl  = c;
        in_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out", out, 64'h0);
    endtask

    logic [63:0] s_exp [4];
    int          lat;
    bit          found;

    initial begin
        rst = 1'b1; in_ctrl = '0; in_valid = 1'b0; lut_we = 1'b0; lut_addr = '0; lut_data = '0;
        s_rst = 1'b1; s_ctrl = '0; s_valid = 1'b0; s_lut_we = 1'b0; s_lut_addr = '0; s_lut_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0; s_rst = 1'b0;

        // single batch, ramp input
        load_lut();
        for (int k = 0; k < DEPTH; k++) send(N'(k % (2**N)));
        in_valid = 1'b0;
        found = 0; lat = 0;
        for (int c = 1; c <= 8 && !found; c++) begin
            @(negedge clk);
            if (out_first) begin found = 1; lat = c; end
        end
        chk("t1_first_seen", 64'(found), 64'h1);
        chk("t1_latency", 64'(lat), 64'd3);
        chk("t1_first_val", out, 64'h41700000_C1700000);   // LUT[15] = {15.0, -15.0}
        @(negedge clk);
        chk("t1_second_val", out, 64'h41600000_C1600000);  // LUT[14] = {14.0, -14.0}
        idle(DEPTH + 4);

        // three continuous batches
        for (int k = 0; k < 3 * DEPTH; k++) send(N'($urandom_range(2**N - 1)));
        idle(DEPTH + 6);

        // 50% input duty
        for (int k = 0; k < DEPTH; k++) begin
            send(N'($urandom_range(2**N - 1)));
            idle(1);
        end
        idle(DEPTH + 6);

        // LUT[0] rewritten on the edge where the first 0 is looked up
        for (int k = 0; k < DEPTH; k++) send('0);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        lut_we = 1'b1; lut_addr = '0; lut_data = 64'h40A00000_00000000;
        @(negedge clk);
        lut_we = 1'b0;
        chk("lutwr_old_val", out, 64'h0);
        chk("lutwr_old_first", 64'(out_first), 64'h1);
        @(negedge clk);
        chk("lutwr_new_val", out, 64'h40A00000_00000000);
        idle(DEPTH + 4);

        // reset mid-replay
        for (int k = 0; k < DEPTH; k++) send(N'($urandom_range(2**N - 1)));
        idle(6);
        pulse_rst();
        idle(DEPTH + 4);

        // reset mid-fill, then a clean batch
        load_lut();
        for (int k = 0; k < 7; k++) send(N'($urandom_range(2**N - 1)));
        pulse_rst();
        load_lut();
        for (int k = 0; k < DEPTH; k++) send(N'($urandom_range(2**N - 1)));
        idle(DEPTH + 6);

        // DEPTH=4, N=1 corner: inputs 1,0,1,0 replay as LUT[0],LUT[1],LUT[0],LUT[1]
        s_lut_we = 1'b1; s_lut_addr = 1'b0; s_lut_data = 64'h3F800000_BF800000;
        @(negedge clk);
        s_lut_addr = 1'b1; s_lut_data = 64'h40000000_C0000000;
        @(negedge clk);
        s_lut_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_ctrl  = (k % 2 == 0) ? 1'b1 : 1'b0;
            s_valid = 1'b1;
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_exp[0] = 64'h3F800000_BF800000; s_exp[1] = 64'h40000000_C0000000;
        s_exp[2] = 64'h3F800000_BF800000; s_exp[3] = 64'h40000000_C0000000;
        found = 0;
        for (int c = 0; c < 8 && !found; c++) begin
            @(negedge clk);
            if (s_out_valid) found = 1;
        end
        chk("d4_valid_seen", 64'(found), 64'h1);
        for (int j = 0; j < 4; j++) begin
            chk("d4_valid", 64'(s_out_valid), 64'h1);
            chk("d4_val", s_out, s_exp[j]);
            chk("d4_first", 64'(s_out_first), 64'(j == 0));
            chk("d4_last", 64'(s_out_last), 64'(j == 3));
            @(negedge clk);
        end
        chk("d4_done", 64'(s_out_valid), 64'h0);

        idle(4);
        chk("model_drained", 64'(sched.num()), 64'h0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
